// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration initiator: walks a per-mode table of register writes and
// issues each one over the pll_write/pll_busy four-phase handshake, with a per-phase timeout.
module pll_reconfig_seq #(
  parameter int MODE_W  = 2,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode_req,
  input  logic [MODE_W-1:0]       mode_sel,
  output logic [MODE_W+IDX_W-1:0] rom_addr,
  input  logic [38:0]             rom_data,
  output logic [5:0]              pll_addr,
  output logic [31:0]             pll_value,
  output logic                    pll_write,
  input  logic                    pll_busy,
  output logic                    active,
  output logic                    done,
  output logic                    err,
  output logic [MODE_W-1:0]       cur_mode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAITIDLE,
    S_ASSERT,
    S_RELEASE
  } state_t;

  localparam int                TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = '1;

  state_t                    state_q, state_d;
  logic [MODE_W-1:0]         mode_q, mode_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      last_q, last_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic                      pend_q, pend_d;
  logic [MODE_W-1:0]         pend_mode_q, pend_mode_d;
  logic [MODE_W+IDX_W-1:0]   rom_addr_d;
  logic [5:0]                pll_addr_d;
  logic [31:0]               pll_value_d;
  logic                      pll_write_d, active_d, done_d, err_d;
  logic [MODE_W-1:0]         cur_mode_d;
  logic [MODE_W-1:0]         start_mode;
  logic                      timed_out, abort;
  logic                      busy_meta, busy_s;

  // Synchronizer resets to "busy" so nothing issues before the PLL side is seen idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_meta <= 1'b1;
      busy_s    <= 1'b1;
    end else begin
      busy_meta <= pll_busy;
      busy_s    <= busy_meta;
    end
  end

  // A request arriving together with a pending one wins: the latest mode_sel is used.
  assign start_mode = mode_req ? mode_sel : pend_mode_q;
  assign timed_out  = (tmr_q == TMR_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    last_d      = last_q;
    tmr_d       = '0;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    rom_addr_d  = rom_addr;
    pll_addr_d  = pll_addr;
    pll_value_d = pll_value;
    pll_write_d = pll_write;
    active_d    = active;
    done_d      = 1'b0;
    err_d       = err;
    cur_mode_d  = cur_mode;
    abort       = 1'b0;

    if (mode_req) begin
      pend_d      = 1'b1;
      pend_mode_d = mode_sel;
    end

    unique case (state_q)
      S_IDLE: begin
        if (mode_req || pend_q) begin
          mode_d     = start_mode;
          idx_d      = '0;
          active_d   = 1'b1;
          err_d      = 1'b0;
          pend_d     = 1'b0;
          rom_addr_d = {start_mode, {IDX_W{1'b0}}};
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        last_d      = rom_data[38];
        pll_addr_d  = rom_data[37:32];
        pll_value_d = rom_data[31:0];
        state_d     = S_WAITIDLE;
      end
      S_WAITIDLE: begin
        if (!busy_s) begin
          pll_write_d = 1'b1;
          state_d     = S_ASSERT;
        end else if (timed_out) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_ASSERT: begin
        if (busy_s) begin
          pll_write_d = 1'b0;
          state_d     = S_RELEASE;
        end else if (timed_out) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_RELEASE: begin
        if (!busy_s) begin
          if (last_q || idx_q == IDX_MAX) begin
            cur_mode_d = mode_q;
            done_d     = 1'b1;
            active_d   = 1'b0;
            state_d    = S_IDLE;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            rom_addr_d = {mode_q, idx_q + IDX_W'(1)};
            state_d    = S_FETCH;
          end
        end else if (timed_out) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      pll_write_d = 1'b0;
      err_d       = 1'b1;
      active_d    = 1'b0;
      state_d     = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      tmr_q       <= '0;
      pend_q      <= 1'b0;
      pend_mode_q <= '0;
      rom_addr    <= '0;
      pll_addr    <= '0;
      pll_value   <= '0;
      pll_write   <= 1'b0;
      active      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cur_mode    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      rom_addr    <= rom_addr_d;
      pll_addr    <= pll_addr_d;
      pll_value   <= pll_value_d;
      pll_write   <= pll_write_d;
      active      <= active_d;
      done        <= done_d;
      err         <= err_d;
      cur_mode    <= cur_mode_d;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: table ROM plus a CLK_50M model of the
// management-bus bridge (busy = registered(waitrequest | write), 5-cycle waitrequest).
module tb_pll_reconfig_seq;

  logic        clk = 1'b0;
  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = '0;
  logic [5:0]  rom_addr;
  logic [38:0] rom_data;
  logic [5:0]  pll_addr;
  logic [31:0] pll_value;
  logic        pll_write;
  logic        pll_busy;
  logic        active, done, err;
  logic [1:0]  cur_mode;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #10 clk50 = ~clk50;
  end

  pll_reconfig_seq #(.MODE_W(2), .IDX_W(4), .TIMEOUT(100)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_req (mode_req),
    .mode_sel (mode_sel),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pll_addr (pll_addr),
    .pll_value(pll_value),
    .pll_write(pll_write),
    .pll_busy (pll_busy),
    .active   (active),
    .done     (done),
    .err      (err),
    .cur_mode (cur_mode)
  );

  // Table ROM: mode 1 = three writes, mode 2 = sixteen writes without a last bit, mode 3 = one write.
  logic [38:0] rom [64];
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[16] = {1'b0, 6'd0, 32'h0000_0000};
    rom[17] = {1'b0, 6'd4, 32'h0001_0101};
    rom[18] = {1'b1, 6'd2, 32'h0000_0000};
    for (int i = 0; i < 16; i++) rom[32 + i] = {1'b0, 6'(16 + i), 32'hA500_0000 + 32'(i)};
    rom[48] = {1'b1, 6'd63, 32'hDEAD_BEEF};
  end
  assign rom_data = rom[rom_addr];

  // Bridge model on CLK_50M; every rising edge of pll_write is logged as one bus write.
  logic       wr_d = 1'b0;
  logic       busy_r = 1'b0;
  logic       stuck = 1'b0;
  int         wreq_cnt = 0;
  logic [5:0]  log_a[$];
  logic [31:0] log_v[$];

  always @(posedge clk50) begin
    wr_d <= pll_write;
    if (pll_write && !wr_d) begin
      log_a.push_back(pll_addr);
      log_v.push_back(pll_value);
      wreq_cnt <= 5;
    end else if (wreq_cnt != 0) begin
      wreq_cnt <= wreq_cnt - 1;
    end
    busy_r <= (wreq_cnt != 0) || pll_write;
  end
  assign pll_busy = busy_r | stuck;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Address/value must hold while a write is requested.
  logic [5:0]  prev_a = '0;
  logic [31:0] prev_v = '0;
  logic        prev_w = 1'b0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_w && !reset) begin
      check("stable_addr", pll_addr, prev_a);
      check("stable_value", pll_value, prev_v);
    end
    prev_a = pll_addr;
    prev_v = pll_value;
    prev_w = pll_write;
  end

  task automatic req(input logic [1:0] m);
    @(negedge clk);
    mode_sel = m;
    mode_req = 1'b1;
    @(negedge clk);
    mode_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [5:0] a, input logic [31:0] v);
    check({tag, "_addr"}, log_a[i], a);
    check({tag, "_value"}, log_v[i], v);
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    // Reset state
    idle_wait(4);
    check("rst_write", pll_write, 1'b0);
    check("rst_addr", pll_addr, 6'd0);
    check("rst_value", pll_value, 32'd0);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cur_mode", cur_mode, 2'd0);
    check("rst_rom_addr", rom_addr, 6'd0);
    reset = 1'b0;
    idle_wait(5);

    // Mode 1: three writes 0,4,2
    log_a.delete(); log_v.delete();
    base = done_cnt;
    req(2'd1);
    check("m1_active", active, 1'b1);
    wait_done("m1_done", 400);
    idle_wait(3);
    check("m1_nwr", log_a.size(), 3);
    check_wr("m1_w0", 0, 6'd0, 32'h0000_0000);
    check_wr("m1_w1", 1, 6'd4, 32'h0001_0101);
    check_wr("m1_w2", 2, 6'd2, 32'h0000_0000);
    check("m1_done_cnt", done_cnt - base, 1);
    check("m1_cur_mode", cur_mode, 2'd1);
    check("m1_active_end", active, 1'b0);
    check("m1_err", err, 1'b0);

    // Mode 2: index wraps at 15 without a last bit
    log_a.delete(); log_v.delete();
    base = done_cnt;
    req(2'd2);
    wait_done("m2_done", 1000);
    idle_wait(40);
    check("m2_nwr", log_a.size(), 16);
    for (int i = 0; i < 16; i++) check_wr("m2_w", i, 6'(16 + i), 32'hA500_0000 + 32'(i));
    check("m2_done_cnt", done_cnt - base, 1);
    check("m2_cur_mode", cur_mode, 2'd2);

    // Requests during an active sequence: latest (mode 2) wins, mode 3 never runs
    log_a.delete(); log_v.delete();
    base = done_cnt;
    req(2'd1);
    idle_wait(3);
    req(2'd3);
    idle_wait(2);
    req(2'd2);
    wait_done("pend_done1", 400);
    check("pend_cur_mode1", cur_mode, 2'd1);
    @(negedge clk);
    check("pend_gap", active, 1'b1);
    wait_done("pend_done2", 1000);
    check("pend_cur_mode2", cur_mode, 2'd2);
    idle_wait(40);
    check("pend_nwr", log_a.size(), 19);
    check_wr("pend_w0", 0, 6'd0, 32'h0000_0000);
    check_wr("pend_w2", 2, 6'd2, 32'h0000_0000);
    check_wr("pend_w3", 3, 6'd16, 32'hA500_0000);
    check_wr("pend_w18", 18, 6'd31, 32'hA500_000F);
    check("pend_done_cnt", done_cnt - base, 2);

    // Timeout: busy stuck high after the first write
    log_a.delete(); log_v.delete();
    base = done_cnt;
    req(2'd1);
    n = 0;
    while (log_a.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_first_wr", log_a.size(), 1);
    stuck = 1'b1;
    n = 0;
    while (!err && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("to_err", err, 1'b1);
    check("to_window", (n >= 98 && n <= 112), 1'b1);
    check("to_write", pll_write, 1'b0);
    check("to_active", active, 1'b0);
    check("to_cur_mode", cur_mode, 2'd2);
    idle_wait(20);
    check("to_err_sticky", err, 1'b1);
    check("to_no_done", done_cnt - base, 0);
    stuck = 1'b0;
    idle_wait(20);

    // New request clears err
    log_a.delete(); log_v.delete();
    req(2'd3);
    check("m3_err_clr", err, 1'b0);
    check("m3_active", active, 1'b1);
    wait_done("m3_done", 400);
    check("m3_cur_mode", cur_mode, 2'd3);
    idle_wait(10);
    check("m3_nwr", log_a.size(), 1);
    check_wr("m3_w0", 0, 6'd63, 32'hDEAD_BEEF);

    // Reset while pll_write is high
    req(2'd2);
    n = 0;
    while (!pll_write && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rw_write_seen", pll_write, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rw_write", pll_write, 1'b0);
    check("rw_addr", pll_addr, 6'd0);
    check("rw_value", pll_value, 32'd0);
    check("rw_active", active, 1'b0);
    check("rw_err", err, 1'b0);
    check("rw_cur_mode", cur_mode, 2'd0);
    check("rw_rom_addr", rom_addr, 6'd0);
    idle_wait(2);
    reset = 1'b0;
    idle_wait(20);
    log_a.delete(); log_v.delete();
    req(2'd1);
    wait_done("rw_done", 400);
    idle_wait(10);
    check("rw_nwr", log_a.size(), 3);
    check_wr("rw_w0", 0, 6'd0, 32'h0000_0000);
    check_wr("rw_w1", 1, 6'd4, 32'h0001_0101);
    check("rw_cur_mode_end", cur_mode, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
